// File: rtl/decode_issue_queue.sv
// Circular issue queue between decode and issue: in-order, format-agnostic packet storage
// with registered skid-based stall and a sticky overflow flag.
module decode_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int PACKET_W = 175,
    parameter int SKID     = 2
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       enable_i,
    input  logic [PACKET_W-1:0]        packet_i,
    input  logic                       flush_i,
    input  logic                       issueReady_i,
    output logic                       issueValid_o,
    output logic [PACKET_W-1:0]        packet_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SKID);

    logic [PACKET_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_stall;
    logic                r_overflow;

    logic                w_pop;
    logic                w_push;
    logic [CNT_W-1:0]    w_count_nxt;

    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign w_pop  = (r_count != '0) && issueReady_i;
    assign w_push = enable_i && ((r_count < FULL_CNT) || w_pop);

    always_comb begin
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (flush_i) begin
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_stall <= (w_count_nxt >= STALL_CNT);
            if (flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_count <= w_count_nxt;
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end else if (enable_i) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Payload storage carries no reset; validity is tracked only by the pointers and count.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= packet_i;
        end
    end

    assign issueValid_o = (r_count != '0);
    assign packet_o     = r_mem[r_rd_ptr];
    assign stall_o      = r_stall;
    assign count_o      = r_count;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Randomized scoreboard bench for decode_issue_queue against a queue-based reference model.
module tb_decode_issue_queue;

    localparam int DEPTH    = 4;
    localparam int PACKET_W = 175;
    localparam int SKID     = 2;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic                clock_i = 1'b0;
    logic                reset_i = 1'b1;
    logic                enable_i = 1'b0;
    logic [PACKET_W-1:0] packet_i = '0;
    logic                flush_i = 1'b0;
    logic                issueReady_i = 1'b0;
    logic                issueValid_o;
    logic [PACKET_W-1:0] packet_o;
    logic                stall_o;
    logic [CNT_W-1:0]    count_o;
    logic                overflow_o;

    decode_issue_queue #(.DEPTH(DEPTH), .PACKET_W(PACKET_W), .SKID(SKID)) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .packet_i     (packet_i),
        .flush_i      (flush_i),
        .issueReady_i (issueReady_i),
        .issueValid_o (issueValid_o),
        .packet_o     (packet_o),
        .stall_o      (stall_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clock_i = ~clock_i;

    // Reference model: queue contents, sticky overflow, registered stall.
    logic [PACKET_W-1:0] model_q[$];
    logic [PACKET_W-1:0] exp_q[$];
    bit                  m_ovf   = 1'b0;
    bit                  m_stall = 1'b0;
    bit                  started = 1'b0;
    int                  n_cmp = 0;
    int                  n_err = 0;

    function automatic logic [PACKET_W-1:0] rand_pkt();
        logic [PACKET_W-1:0] p = '0;
        for (int i = 0; i < (PACKET_W + 31) / 32; i++) begin
            p = (p << 32) | PACKET_W'($urandom);
        end
        return p;
    endfunction

    task automatic cycle(input bit en, input bit rdy, input bit fl, input bit rst);
        logic [PACKET_W-1:0] pkt;
        bit pop;
        bit push;
        @(negedge clock_i);
        #1;
        pkt          = rand_pkt();
        enable_i     = en;
        issueReady_i = rdy;
        flush_i      = fl;
        reset_i      = rst;
        packet_i     = pkt;
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            m_ovf = 1'b0;
        end else if (fl) begin
            model_q.delete();
            exp_q.delete();
        end else begin
            pop  = (model_q.size() != 0) && rdy;
            push = en && ((model_q.size() < DEPTH) || pop);
            if (pop) void'(model_q.pop_front());
            if (push) begin
                model_q.push_back(pkt);
                exp_q.push_back(pkt);
            end else if (en) begin
                m_ovf = 1'b1;
            end
        end
        m_stall = (model_q.size() >= DEPTH - SKID);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: status at the falling edge, then the issued packet once inputs settle.
    initial begin
        logic [PACKET_W-1:0] want;
        wait (started);
        forever begin
            @(negedge clock_i);
            n_cmp++;
            if (count_o !== CNT_W'(model_q.size())) begin
                n_err++;
                $display("FAIL count: got %0d expected %0d at %0t", count_o, model_q.size(), $time);
            end
            check_bit("issueValid", issueValid_o, model_q.size() != 0);
            check_bit("stall", stall_o, m_stall);
            check_bit("overflow", overflow_o, m_ovf);
            #2;
            if (issueValid_o === 1'b1 && issueReady_i && !flush_i && !reset_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL issue_order: got unexpected packet %h, none expected at %0t", packet_o, $time);
                end else begin
                    want = exp_q.pop_front();
                    if (packet_o !== want) begin
                        n_err++;
                        $display("FAIL issue_packet: got %h expected %h at %0t", packet_o, want, $time);
                    end
                end
            end
        end
    end

    initial begin
        started = 1'b1;
        cycle(0, 0, 0, 1);
        // Single push, held at the head
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        // Fill past full, overflow, then drain
        repeat (6) cycle(1, 0, 0, 0);
        repeat (6) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        // Full queue, push with simultaneous pop
        repeat (4) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        repeat (6) cycle(0, 1, 0, 0);
        // Continuous streaming through wrapping pointers
        repeat (12) cycle(1, 1, 0, 0);
        repeat (2) cycle(0, 1, 0, 0);
        // Flush with concurrent push and pop, then reuse
        repeat (3) cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        // Reset while occupied with overflow set
        repeat (7) cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99) < 70), ($urandom_range(99) < 50),
                  ($urandom_range(99) < 2), ($urandom_range(199) < 1));
        end
        repeat (DEPTH + 2) cycle(0, 1, 0, 0);
        @(negedge clock_i);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_issue_queue.md
DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of queue entries (power of two, >= 4).
REQ-002 SHALL provide parameter PACKET_W, default 175, width of one decoded-instruction packet.
REQ-003 SHALL provide parameter SKID, default 2, free entries held back for in-flight decode results.
REQ-004 clock_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  reset, synchronous and active-high.
REQ-006 enable_i  input  1  push strobe: decode stage 2 presents a valid instruction this cycle.
REQ-007 packet_i  input  PACKET_W  decoded bundle, MSB-first: imm(64), immEnable, reg1/2/3(3x5), reg1/2/3Enable, reg3IsImmediate, bit1, bit2, bit1/2Enable, reg2ValOrZero, instructionAddress(64), opcode(6), xOpcode(10), xOpcodeEnable, instructionFormat(5).
REQ-008 flush_i  input  1  discard all queued entries (branch redirect).
REQ-009 issueReady_i  input  1  issue stage accepts the head entry this cycle.
REQ-010 issueValid_o  output  1  head entry valid.
REQ-011 packet_o  output  PACKET_W  head entry, bit-identical to the pushed packet_i.
REQ-012 stall_o  output  1  registered back-pressure to fetch/decode.
REQ-013 count_o  output  log2(DEPTH)+1  current occupancy.
REQ-014 overflow_o  output  1  sticky error: a push was dropped.

Function
REQ-015 Storage SHALL be a circular buffer with DEPTH entries, log2(DEPTH)-bit read and write pointers wrapping from DEPTH-1 to 0.
REQ-016 Push SHALL occur when enable_i=1 and (count<DEPTH or a pop occurs in the same cycle); the packet is written at the write pointer, which then increments.
REQ-017 Pop SHALL occur when issueValid_o=1 and issueReady_i=1; the read pointer increments.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and are legal at count=DEPTH and at count=0 is impossible (no pop when empty).
REQ-019 Push at count=DEPTH without a same-cycle pop SHALL be dropped, pointers/count unchanged, overflow_o set to 1 and held until reset.
REQ-020 issueValid_o SHALL equal (count!=0); packet_o SHALL be storage[read pointer] with no extra register stage.
REQ-021 Latency: packet pushed at edge N into an empty queue SHALL appear on packet_o with issueValid_o=1 in the cycle after edge N (no bypass of packet_i).
REQ-022 stall_o SHALL be a register updated each edge to (next count >= DEPTH-SKID).
REQ-023 Entries SHALL issue strictly in push order.
REQ-024 flush_i=1 SHALL, at the edge, zero both pointers and count, clear stall_o, ignore same-cycle push and pop, and leave overflow_o unchanged.
REQ-025 Storage contents need not be cleared by flush or reset; only valid-tracking state is defined.
REQ-026 The block SHALL inspect no packet fields; it is format-agnostic.

Reset
REQ-027 reset_i=1 at an edge SHALL set count_o=0, both pointers=0, issueValid_o=0, stall_o=0, overflow_o=0, overriding flush, push and pop.
REQ-028 Reset asserted mid-operation SHALL discard all entries; the first push after reset deasserts lands in entry 0.

Verification
REQ-029 Reset, push A (imm=0x1234, opcode=14) with issueReady_i=0 -> next cycle issueValid_o=1, packet_o=A, count_o=1.
REQ-030 DEPTH=4, push 4 packets A..D, no pops -> count_o=4, stall_o=1 once count reaches 2; fifth push E -> dropped, overflow_o=1, pops yield A,B,C,D then issueValid_o=0.
REQ-031 count=4, push E with issueReady_i=1 same cycle -> A issued, E accepted, count_o stays 4, overflow_o stays 0; E emerges fifth.
REQ-032 Continuous push+pop for 10 packets with issueReady_i=1 -> count_o=1 steady, pointers wrap, output order matches input order, stall_o never asserts.
REQ-033 count=3, flush_i=1 with enable_i=1 and issueReady_i=1 -> next cycle count_o=0, issueValid_o=0, stall_o=0; next push lands at entry 0 and issues.
REQ-034 count=3 with overflow_o=1, assert reset_i for one cycle -> count_o=0, issueValid_o=0, stall_o=0, overflow_o=0.
